// File: rtl/bitonic4_stream_sorter_pkg.sv
// Shared types and helpers for the 4-element streaming bitonic sorter.
// Holds the block length, the FSM state encoding and the pad-value helper.
package bitonic_pkg;

  localparam int BLK_LEN = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Wide enough to hold a block length of 1..4 as well as index 0..3
  typedef logic [2:0] cnt_t;

  // Pad sorts to the tail: all-ones when ascending, all-zeros when descending
  function automatic logic [63:0] pad_word(input logic is_asc, input int size_data);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < size_data) w[i] = is_asc;
    end
    return w;
  endfunction

endpackage

// File: rtl/bitonic4_stream_sorter_block4.sv
// Combinational 4-input bitonic sorting network; o_data[0] is emitted first.
// Zero latency, no flow control: purely combinational.
module Bitonic_Block4
  import bitonic_pkg::*;
#(
  parameter bit IS_ASC    = 1'b1,
  parameter int SIZE_DATA = 8
) (
  input  logic [BLK_LEN-1:0][SIZE_DATA-1:0] i_data,
  output logic [BLK_LEN-1:0][SIZE_DATA-1:0] o_data
);

  logic [BLK_LEN-1:0][SIZE_DATA-1:0] s1;
  logic [BLK_LEN-1:0][SIZE_DATA-1:0] s2;

  // Returns {first, second}; with up=1 the smaller value comes first
  function automatic logic [2*SIZE_DATA-1:0] cas(
    input logic [SIZE_DATA-1:0] a,
    input logic [SIZE_DATA-1:0] b,
    input logic                 up
  );
    if (up ? (a > b) : (a < b)) return {b, a};
    return {a, b};
  endfunction

  always_comb begin
    // Opposing directions in the first stage make the 4-sequence bitonic
    {s1[0], s1[1]}         = cas(i_data[0], i_data[1], IS_ASC);
    {s1[2], s1[3]}         = cas(i_data[2], i_data[3], !IS_ASC);
    {s2[0], s2[2]}         = cas(s1[0], s1[2], IS_ASC);
    {s2[1], s2[3]}         = cas(s1[1], s1[3], IS_ASC);
    {o_data[0], o_data[1]} = cas(s2[0], s2[1], IS_ASC);
    {o_data[2], o_data[3]} = cas(s2[2], s2[3], IS_ASC);
  end

endmodule

// File: rtl/bitonic4_stream_sorter.sv
// Collects up to 4 elements, sorts once, drains serially; first output 2 edges after block close.
// Input and output never overlap; o_data/o_last hold while stalled by i_ready.
module bitonic4_stream_sorter
  import bitonic_pkg::*;
#(
  parameter bit IS_ASC    = 1'b1,
  parameter int SIZE_DATA = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_blk_cnt
);

  localparam logic [SIZE_DATA-1:0] PAD = SIZE_DATA'(pad_word(IS_ASC, SIZE_DATA));

  state_t                            state;
  cnt_t                              fill_cnt;
  cnt_t                              rd_idx;
  cnt_t                              blk_len;
  logic                              ready_q;
  logic [BLK_LEN-1:0][SIZE_DATA-1:0] in_buf;
  logic [BLK_LEN-1:0][SIZE_DATA-1:0] out_buf;
  logic [BLK_LEN-1:0][SIZE_DATA-1:0] sort_in;
  logic [BLK_LEN-1:0][SIZE_DATA-1:0] sort_out;

  always_comb begin
    sort_in = '0;
    for (int k = 0; k < BLK_LEN; k++) begin
      sort_in[k] = (cnt_t'(k) < blk_len) ? in_buf[k] : PAD;
    end
  end

  Bitonic_Block4 #(
    .IS_ASC    (IS_ASC),
    .SIZE_DATA (SIZE_DATA)
  ) u_block4 (
    .i_data (sort_in),
    .o_data (sort_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      rd_idx    <= '0;
      blk_len   <= '0;
      ready_q   <= 1'b0;
      in_buf    <= '0;
      out_buf   <= '0;
      o_blk_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          ready_q <= 1'b1;
          if (i_valid && ready_q) begin
            in_buf[fill_cnt[1:0]] <= i_data;
            fill_cnt              <= fill_cnt + cnt_t'(1);
            if (fill_cnt == cnt_t'(BLK_LEN - 1) || i_last) begin
              blk_len <= fill_cnt + cnt_t'(1);
              ready_q <= 1'b0;
              state   <= SORT;
            end
          end
        end
        SORT: begin
          out_buf  <= sort_out;
          fill_cnt <= '0;
          ready_q  <= 1'b0;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (i_ready) begin
            if (rd_idx == blk_len - cnt_t'(1)) begin
              rd_idx    <= '0;
              o_blk_cnt <= o_blk_cnt + CNT_W'(1);
              ready_q   <= 1'b1;
              state     <= FILL;
            end else begin
              rd_idx <= rd_idx + cnt_t'(1);
            end
          end
        end
        default: begin
          ready_q <= 1'b0;
          state   <= FILL;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (state == DRAIN);
  assign o_data  = o_valid ? out_buf[rd_idx[1:0]] : '0;
  assign o_last  = o_valid && (rd_idx == blk_len - cnt_t'(1));
  assign o_busy  = (state != FILL) || (fill_cnt != '0);

endmodule

// File: tb/tb_bitonic4_stream_sorter.sv
// Runs an ascending (2-bit counter) and a descending (8-bit counter) sorter in lockstep
// against a queue-based sorting model with a decoupled output monitor.
module tb_bitonic4_stream_sorter;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_rdy = 1'b1;

  logic       a_ready, a_valid, a_last, a_busy;
  logic [7:0] a_data;
  logic [1:0] a_cnt;
  logic       d_ready, d_valid, d_last, d_busy;
  logic [7:0] d_data;
  logic [7:0] d_cnt;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   hs_count = 0;
  int   rdy_mode = 0;
  exp_t qa[$];
  exp_t qd[$];
  bit   stall = 0;
  logic [7:0] prev_d;
  logic       prev_l;

  always #5 clk = ~clk;

  bitonic4_stream_sorter #(.IS_ASC(1'b1), .SIZE_DATA(8), .CNT_W(2)) u_asc (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(a_ready), .i_data(in_data),
    .i_last(in_last), .o_valid(a_valid), .i_ready(out_rdy), .o_data(a_data),
    .o_last(a_last), .o_busy(a_busy), .o_blk_cnt(a_cnt)
  );

  bitonic4_stream_sorter #(.IS_ASC(1'b0), .SIZE_DATA(8), .CNT_W(8)) u_dsc (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(d_ready), .i_data(in_data),
    .i_last(in_last), .o_valid(d_valid), .i_ready(out_rdy), .o_data(d_data),
    .o_last(d_last), .o_busy(d_busy), .o_blk_cnt(d_cnt)
  );

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Consumer readiness pattern
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = !out_rdy;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples on the falling edge, handshakes complete on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qd.delete();
      exp_cnt = 0;
      stall   = 0;
    end else begin
      chk(a_cnt == 2'(exp_cnt), "blk_cnt_asc", int'(a_cnt), exp_cnt % 4);
      chk(d_cnt == 8'(exp_cnt), "blk_cnt_dsc", int'(d_cnt), exp_cnt % 256);
      chk(d_valid == a_valid, "valid_lockstep", int'(d_valid), int'(a_valid));
      if (stall) chk(a_valid && a_data == prev_d && a_last == prev_l, "hold_stalled", int'(a_data), int'(prev_d));
      if (a_valid) begin
        chk(!a_ready && !d_ready, "ready_low_in_drain", int'(a_ready), 0);
        if (out_rdy) begin
          if (qa.size() == 0 || qd.size() == 0) begin
            chk(1'b0, "unexpected_output", int'(a_data), -1);
          end else begin
            exp_t ea, ed;
            ea = qa.pop_front();
            ed = qd.pop_front();
            chk(a_data == ea.d, "data_asc", int'(a_data), int'(ea.d));
            chk(a_last == ea.l, "last_asc", int'(a_last), int'(ea.l));
            chk(d_data == ed.d, "data_dsc", int'(d_data), int'(ed.d));
            chk(d_last == ed.l, "last_dsc", int'(d_last), int'(ed.l));
            if (ea.l) exp_cnt++;
            hs_count++;
          end
        end
        stall  = !out_rdy;
        prev_d = a_data;
        prev_l = a_last;
      end else begin
        stall = 0;
      end
    end
  end

  task automatic send_block(input int n, input int x0, input int x1, input int x2, input int x3,
                            input bit gaps);
    int         x[4];
    logic [7:0] v[$];
    logic [7:0] sa[$];
    logic [7:0] sd[$];
    exp_t       e;
    bit         acc;
    x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
    for (int i = 0; i < n; i++) v.push_back(8'(x[i]));
    sa = v; sa.sort();
    sd = v; sd.rsort();
    for (int i = 0; i < n; i++) begin
      e.l = (i == n - 1);
      e.d = sa[i]; qa.push_back(e);
      e.d = sd[i]; qd.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = (i == n - 1);
      acc = 1'b0;
      for (int c = 0; c < 400 && !acc; c++) begin
        acc = a_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk(1'b0, "accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk(!a_valid && !a_ready && a_busy, "sort_cycle", int'({a_valid, a_ready, a_busy}), 1);
    @(posedge clk); #1;
    chk(a_valid && d_valid, "first_valid_latency", int'(a_valid), 1);
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 400; c++) begin
      if (!a_busy && qa.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(c < 400, "drain_timeout", c, 400);
    chk(!a_busy && !d_busy, "idle_after_drain", int'(a_busy), 0);
    chk(a_ready && d_ready, "ready_after_drain", int'(a_ready), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk(!a_valid && !d_valid, "rst_valid", int'(a_valid), 0);
    chk(a_data == 0 && !a_last && d_data == 0 && !d_last, "rst_data_last", int'(a_data), 0);
    chk(!a_busy && !d_busy, "rst_busy", int'(a_busy), 0);
    chk(a_cnt == 0 && d_cnt == 0, "rst_blk_cnt", int'(d_cnt), 0);
    chk(!a_ready && !d_ready, "rst_ready_low", int'(a_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk(a_ready && d_ready, "ready_after_release", int'(a_ready), 1);
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 255 : 0;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    int target;
    do_reset();

    // Full ascending block; descending twin sees 9,7,3,1
    send_block(4, 7, 3, 9, 1, 1'b0);
    wait_idle();
    chk(a_cnt == 2'd1 && d_cnt == 8'd1, "blk_cnt_after_first", int'(d_cnt), 1);

    // Short blocks, including a single element
    send_block(2, 5, 2, 0, 0, 1'b0);
    wait_idle();
    send_block(1, 200, 0, 0, 0, 1'b0);
    wait_idle();

    // Alternating backpressure
    rdy_mode = 1;
    send_block(4, 4, 4, 0, 255, 1'b0);
    wait_idle();

    // Pad-value collisions, back to back
    rdy_mode = 0;
    send_block(4, 7, 3, 9, 1, 1'b0);
    send_block(2, 0, 4, 0, 0, 1'b0);
    wait_idle();
    send_block(3, 255, 255, 0, 0, 1'b0);
    wait_idle();

    // Reset after two of four outputs
    send_block(4, 1, 2, 3, 4, 1'b0);
    target = hs_count + 2;
    for (int c = 0; c < 100 && hs_count < target; c++) begin
      @(posedge clk); #1;
    end
    chk(hs_count >= target, "mid_drain_timeout", hs_count, target);
    do_reset();
    send_block(4, 8, 6, 7, 5, 1'b0);
    wait_idle();
    chk(a_cnt == 2'd1 && d_cnt == 8'd1, "blk_cnt_after_reset", int'(d_cnt), 1);

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_block(4, rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0);
      wait_idle();
      chk(a_cnt == 2'(k), "wrap_seq", int'(a_cnt), k % 4);
      chk(d_cnt == 8'(k), "wide_seq", int'(d_cnt), k);
    end

    // Random lengths, data, gaps and backpressure
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      send_block(int'($urandom_range(1, 4)), rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    chk(qa.size() == 0 && qd.size() == 0, "queues_empty", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
